logo_pos_ctrl: RTL and testbench
================================

// Module: logo_pos_ctrl
// PURPOSE
//  Position controller that sits directly upstream of the flying-logo renderer: it turns four raw push-buttons
//  into the logo's top-left screen coordinate (logo_x, logo_y) consumed by the logo_area/ROM-address logic.
//  Buttons are synchronised and debounced, and the position moves once per frame during vertical blanking
//  (no tearing). The position is clamped so the whole logo stays on the 640x480 screen.
// PARAMETERS
//  SCREEN_W     640     active width, pixels
//  SCREEN_H     480     active height, lines
//  LOGO_W       120     logo width; x range 0..SCREEN_W-LOGO_W (520)
//  LOGO_H       160     logo height; y range 0..SCREEN_H-LOGO_H (320)
//  X_INIT       260     reset x
//  Y_INIT       160     reset y
//  STEP         1       pixels moved per update, 1..15
//  DB_CYCLES    250000  stable pclk cycles before a button edge is accepted (10 ms at 25 MHz)
//  FRAME_DIV    1       frame ticks per position update, 1..255
//  VTICK_LINE   480     v_cnt value (first blank line) at which the frame tick fires
//  IDLE_UPDATES 64      button-free updates before auto mode (only with LOGO_AUTO_BOUNCE_EN)
// PORTS
//  pclk       in   1   pixel clock (25 MHz), only clock
//  rst        in   1   synchronous, active-high reset
//  up         in   1   raw button, async; up = decrease y
//  down       in   1   raw button, async; down = increase y
//  left       in   1   raw button, async; left = decrease x
//  right      in   1   raw button, async; right = increase x
//  h_cnt      in   10  horizontal counter from the VGA timing generator
//  v_cnt      in   10  vertical counter from the VGA timing generator
//  logo_x     out  10  logo left column
//  logo_y     out  10  logo top line
//  pos_upd    out  1   1-cycle pulse when logo_x/logo_y changed
//  btn_state  out  4   debounced {up,down,left,right}
//  auto_mode  out  1   1 while in AUTO state
// BEHAVIOUR
//  - Reset (sync, dominates all, including mid-hold or mid-debounce): logo_x=X_INIT, logo_y=Y_INIT; pos_upd,
//    btn_state and auto_mode = 0; sync FFs, debounce/frame/idle counters = 0; state=MANUAL; dir_x=dir_y=+1.
//  - Per button: 2-FF synchroniser. The debounced bit flips only after the synced value differs from it for
//    DB_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
//  - frame_tick: one pclk when h_cnt==0 && v_cnt==VTICK_LINE. The frame divider counts ticks; update fires on
//    the FRAME_DIV-th tick and the divider restarts at 0.
//  - MANUAL update: dx=(right-left), dy=(down-up). Opposing pair gives 0. Diagonals allowed.
//    new = clamp(old + d*STEP, 0, MAX), computed 11-bit signed; no wrap-around.
//  - Registers load on the update cycle. pos_upd is asserted that same cycle iff new != old
//    (a clamped, stationary update gives no pulse).
//  - Latency: button edge -> btn_state = 2 + DB_CYCLES cycles; btn_state -> position = next update.
//  - States: MANUAL, AUTO. AUTO exists only with LOGO_AUTO_BOUNCE_EN.
// CONFIGURATION
//  LOGO_AUTO_BOUNCE_EN defined:
//   - Idle counter counts MANUAL updates with btn_state==0. Any pressed bit clears it.
//   - When the count reaches IDLE_UPDATES: MANUAL->AUTO, auto_mode=1, dir_x=dir_y=+1.
//   - AUTO update: pos += dir*STEP per axis. A result beyond an edge clamps to that edge and flips the axis
//     direction in the same cycle.
//   - Any btn_state bit set at an update: AUTO->MANUAL, that update applied as MANUAL, idle counter cleared.
//  Not defined: no idle counter, no AUTO logic; state fixed MANUAL; auto_mode tied 0; ports unchanged.
// STRUCTURE
//  - logo_pkg: screen/logo size constants, button index constants (BTN_UP=3..BTN_RIGHT=0),
//    state enum {ST_MANUAL, ST_AUTO}.
//  - Sub-module button_debounce (synchroniser + counter, parameter DB_CYCLES), instantiated 4x.
//    Frame tick, divider, clamp arithmetic and FSM stay in the top.
// TESTING (bench overrides DB_CYCLES=16, FRAME_DIV=1, IDLE_UPDATES=4)
//  1 rst 3 cycles -> logo_x=260, logo_y=160, btn_state=0, pos_upd=0, auto_mode=0.
//  2 right held, 10 frame ticks -> logo_x=270, logo_y=160, exactly 10 pos_upd pulses.
//  3 right glitch 10 cycles (<16) -> btn_state[0] stays 0; logo_x stays 260 across ticks.
//  4 STEP=4, left held from x=2 -> x=0 after next tick; further ticks hold 0 with no pos_upd.
//    Same at x=520 holding right.
//  5 left+right held -> x unchanged, no pos_upd; up+right -> x=261, y=159 after one tick.
//  6 Macro on, no buttons, 4 ticks -> auto_mode=1, then x,y +1/tick. At x=520, dir_x flips (next x=519).
//    Press up -> auto_mode=0 at next update.
//    Macro off -> auto_mode stays 0 and position stays fixed.
//  7 rst asserted while down held mid-move -> next cycle x=260, y=160, btn_state=0.

Source files
------------

// File: rtl/logo_pkg.sv
// Shared constants, types and coordinate arithmetic helpers for the logo position controller.
package logo_pkg;

  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_SCREEN_H = 480;
  localparam int unsigned DEF_LOGO_W   = 120;
  localparam int unsigned DEF_LOGO_H   = 160;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CALC_W  = 11;
  localparam int unsigned STEP_W  = 4;

  localparam int unsigned BTN_N     = 4;
  localparam int unsigned BTN_UP    = 3;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_RIGHT = 0;

  typedef enum logic {ST_MANUAL, ST_AUTO} state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

  // Signed old +/- step; opposing inc/dec cancel out.
  function automatic logic signed [CALC_W-1:0] step_sum(input logic [COORD_W-1:0] old,
                                                        input logic inc, input logic dec,
                                                        input logic [STEP_W-1:0] step);
    logic signed [CALC_W-1:0] base;
    logic signed [CALC_W-1:0] delta;
    base  = signed'({1'b0, old});
    delta = signed'(CALC_W'(step));
    if (inc && !dec)      return base + delta;
    else if (dec && !inc) return base - delta;
    else                  return base;
  endfunction

  function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [CALC_W-1:0] s,
                                                     input logic [COORD_W-1:0] max);
    if (s[CALC_W-1])                 return '0;
    else if (s[COORD_W-1:0] > max)   return max;
    else                             return s[COORD_W-1:0];
  endfunction

  function automatic logic at_high_edge(input logic signed [CALC_W-1:0] s,
                                        input logic [COORD_W-1:0] max);
    return !s[CALC_W-1] && (s[COORD_W-1:0] >= max);
  endfunction

  function automatic logic at_low_edge(input logic signed [CALC_W-1:0] s);
    return s[CALC_W-1] || (s == '0);
  endfunction

endpackage

// File: rtl/logo_pos_ctrl_if.sv
// Button, VGA counter and logo position signals between the board/timing side and the controller.
interface logo_pos_if;
  import logo_pkg::*;

  logic               up;
  logic               down;
  logic               left;
  logic               right;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [COORD_W-1:0] logo_x;
  logic [COORD_W-1:0] logo_y;
  logic               pos_upd;
  logic [BTN_N-1:0]   btn_state;
  logic               auto_mode;

  modport master (
    output up, down, left, right, h_cnt, v_cnt,
    input  logo_x, logo_y, pos_upd, btn_state, auto_mode
  );

  modport slave (
    input  up, down, left, right, h_cnt, v_cnt,
    output logo_x, logo_y, pos_upd, btn_state, auto_mode
  );
endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one raw push-button.
module button_debounce #(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic pclk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Counter runs only while the synced level disagrees with the debounced one.
  always_ff @(posedge pclk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/logo_pos_ctrl.sv
// Logo position controller: debounced buttons move the logo once per frame in vertical blanking.
// Optional bounce-on-idle mode is enabled with `define LOGO_AUTO_BOUNCE_EN.
module logo_pos_ctrl
  import logo_pkg::*;
#(
  parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H     = DEF_SCREEN_H,
  parameter int unsigned LOGO_W       = DEF_LOGO_W,
  parameter int unsigned LOGO_H       = DEF_LOGO_H,
  parameter int unsigned X_INIT       = 260,
  parameter int unsigned Y_INIT       = 160,
  parameter int unsigned STEP         = 1,
  parameter int unsigned DB_CYCLES    = 250000,
  parameter int unsigned FRAME_DIV    = 1,
  parameter int unsigned VTICK_LINE   = 480,
  parameter int unsigned IDLE_UPDATES = 64
) (
  input  logic       pclk,
  input  logic       rst,
  logo_pos_if.slave  bus
);
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(SCREEN_W - LOGO_W);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(SCREEN_H - LOGO_H);
  localparam logic [COORD_W-1:0] VTICK_V  = COORD_W'(VTICK_LINE);
  localparam logic [STEP_W-1:0]  STEP_V   = STEP_W'(STEP);
  localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);

  logic [BTN_N-1:0] btn_raw;
  logic [BTN_N-1:0] btn_db;

  assign btn_raw[BTN_UP]    = bus.up;
  assign btn_raw[BTN_DOWN]  = bus.down;
  assign btn_raw[BTN_LEFT]  = bus.left;
  assign btn_raw[BTN_RIGHT] = bus.right;

  for (genvar i = 0; i < BTN_N; i++) begin : g_db
    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .pclk (pclk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .db   (btn_db[i])
    );
  end

  logic       tick_c;
  logic       upd_c;
  logic [7:0] div_q;

  assign tick_c = (bus.h_cnt == '0) && (bus.v_cnt == VTICK_V);
  assign upd_c  = tick_c && (div_q == DIV_LAST);

  state_e state_q, state_d;
  pos_t   pos_q, pos_d;
  logic   pos_upd_q, pos_upd_d;
  logic   auto_q;

  logic [COORD_W-1:0] man_x_c;
  logic [COORD_W-1:0] man_y_c;

  assign man_x_c = clamp_coord(step_sum(pos_q.x, btn_db[BTN_RIGHT], btn_db[BTN_LEFT], STEP_V), X_MAX);
  assign man_y_c = clamp_coord(step_sum(pos_q.y, btn_db[BTN_DOWN], btn_db[BTN_UP], STEP_V), Y_MAX);

`ifdef LOGO_AUTO_BOUNCE_EN
  localparam int unsigned IDLE_W = $clog2(IDLE_UPDATES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_UPDATES - 1);

  logic              dir_x_q, dir_x_d;
  logic              dir_y_q, dir_y_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic signed [CALC_W-1:0] ax_sum_c;
  logic signed [CALC_W-1:0] ay_sum_c;
  logic                     flip_x_c;
  logic                     flip_y_c;

  // dir = 1 moves towards the far edge; reaching an edge reverses that axis.
  assign ax_sum_c = step_sum(pos_q.x, dir_x_q, !dir_x_q, STEP_V);
  assign ay_sum_c = step_sum(pos_q.y, dir_y_q, !dir_y_q, STEP_V);
  assign flip_x_c = dir_x_q ? at_high_edge(ax_sum_c, X_MAX) : at_low_edge(ax_sum_c);
  assign flip_y_c = dir_y_q ? at_high_edge(ay_sum_c, Y_MAX) : at_low_edge(ay_sum_c);
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= ST_MANUAL;
      pos_q.x   <= COORD_W'(X_INIT);
      pos_q.y   <= COORD_W'(Y_INIT);
      pos_upd_q <= 1'b0;
      auto_q    <= 1'b0;
      div_q     <= '0;
`ifdef LOGO_AUTO_BOUNCE_EN
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      pos_upd_q <= pos_upd_d;
      auto_q    <= (state_d == ST_AUTO);
      if (tick_c) begin
        div_q <= upd_c ? '0 : div_q + 8'd1;
      end
`ifdef LOGO_AUTO_BOUNCE_EN
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      idle_q    <= idle_d;
`endif
    end
  end

  // Next state and position; everything moves only on the update cycle.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    pos_upd_d = 1'b0;
`ifdef LOGO_AUTO_BOUNCE_EN
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    idle_d    = idle_q;
`endif
    if (upd_c) begin
      case (state_q)
        ST_MANUAL: begin
          pos_d.x = man_x_c;
          pos_d.y = man_y_c;
`ifdef LOGO_AUTO_BOUNCE_EN
          if (btn_db != '0) begin
            idle_d = '0;
          end else if (idle_q == IDLE_LAST) begin
            idle_d  = '0;
            state_d = ST_AUTO;
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
`endif
        end
`ifdef LOGO_AUTO_BOUNCE_EN
        ST_AUTO: begin
          if (btn_db != '0) begin
            state_d = ST_MANUAL;
            idle_d  = '0;
            pos_d.x = man_x_c;
            pos_d.y = man_y_c;
          end else begin
            pos_d.x = clamp_coord(ax_sum_c, X_MAX);
            pos_d.y = clamp_coord(ay_sum_c, Y_MAX);
            if (flip_x_c) dir_x_d = !dir_x_q;
            if (flip_y_c) dir_y_d = !dir_y_q;
          end
        end
`endif
        default: begin
          state_d = ST_MANUAL;
        end
      endcase
      pos_upd_d = (pos_d != pos_q);
    end
  end

  assign bus.logo_x    = pos_q.x;
  assign bus.logo_y    = pos_q.y;
  assign bus.pos_upd   = pos_upd_q;
  assign bus.btn_state = btn_db;
  assign bus.auto_mode = auto_q;
endmodule

// File: tb/tb_logo_pos_ctrl.sv
// Directed self-checking bench for logo_pos_ctrl (STEP=1 instance plus a STEP=4 instance for clamping).
module tb_logo_pos_ctrl;
  import logo_pkg::*;

  localparam int unsigned DB = 16;

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic [9:0] hc   = 10'd1;
  logic [9:0] vc   = 10'd0;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  logo_pos_if bus ();
  logo_pos_if bus4 ();

  assign bus.h_cnt  = hc;
  assign bus.v_cnt  = vc;
  assign bus4.h_cnt = hc;
  assign bus4.v_cnt = vc;

  logo_pos_ctrl #(.STEP(1), .DB_CYCLES(DB), .FRAME_DIV(1), .IDLE_UPDATES(4)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  logo_pos_ctrl #(.STEP(4), .X_INIT(2), .DB_CYCLES(DB), .FRAME_DIV(1), .IDLE_UPDATES(4)) dut4 (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus4)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic set_btn(input logic [3:0] b);
    bus.up = b[3]; bus.down = b[2]; bus.left = b[1]; bus.right = b[0];
  endtask

  task automatic set_btn4(input logic [3:0] b);
    bus4.up = b[3]; bus4.down = b[2]; bus4.left = b[1]; bus4.right = b[0];
  endtask

  task automatic settle();
    cycles(DB + 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_btn(4'b0000);
    set_btn4(4'b0000);
    cycles(3);
    rst = 1'b0;
  endtask

  // One frame tick; returns the pos_upd levels seen the cycle after the update edge.
  task automatic tick(output logic p, output logic p4);
    hc = 10'd0; vc = 10'd480;
    @(negedge pclk);
    hc = 10'd1; vc = 10'd0;
    p  = bus.pos_upd;
    p4 = bus4.pos_upd;
    @(negedge pclk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.logo_x !== 10'd260 || bus.logo_y !== 10'd160) begin
      failures++;
      $display("FAIL reset_pos: got x=%0d y=%0d, want x=260 y=160", bus.logo_x, bus.logo_y);
    end
    checks++;
    if (bus.btn_state !== 4'b0000 || bus.pos_upd !== 1'b0 || bus.auto_mode !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got btn=%b upd=%b auto=%b, want 0000 0 0",
               bus.btn_state, bus.pos_upd, bus.auto_mode);
    end
  endtask

  task automatic test_debounce_latency();
    do_reset();
    set_btn(4'b0001);
    cycles(DB + 1);
    checks++;
    if (bus.btn_state !== 4'b0000) begin
      failures++;
      $display("FAIL db_early: got btn=%b after %0d cycles, want 0000", bus.btn_state, DB + 1);
    end
    cycles(1);
    checks++;
    if (bus.btn_state !== 4'b0001) begin
      failures++;
      $display("FAIL db_latency: got btn=%b after %0d cycles, want 0001", bus.btn_state, DB + 2);
    end
  endtask

  task automatic test_right_hold();
    logic p, p4;
    int pulses;
    pulses = 0;
    settle();
    for (int i = 0; i < 10; i++) begin
      tick(p, p4);
      if (p === 1'b1) pulses++;
    end
    checks++;
    if (bus.logo_x !== 10'd270 || bus.logo_y !== 10'd160) begin
      failures++;
      $display("FAIL right_hold_pos: got x=%0d y=%0d, want x=270 y=160", bus.logo_x, bus.logo_y);
    end
    checks++;
    if (pulses != 10) begin
      failures++;
      $display("FAIL right_hold_pulses: got %0d, want 10", pulses);
    end
    checks++;
    if (bus.pos_upd !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width: got pos_upd=%b two cycles after update, want 0", bus.pos_upd);
    end
  endtask

  task automatic test_glitch();
    logic p, p4;
    logic seen;
    int pulses;
    do_reset();
    seen = 1'b0;
    pulses = 0;
    set_btn(4'b0001);
    cycles(10);
    set_btn(4'b0000);
    for (int i = 0; i < 30; i++) begin
      @(negedge pclk);
      if (bus.btn_state[0] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL glitch_btn: got btn_state[0] high after 10-cycle glitch, want 0");
    end
    for (int i = 0; i < 3; i++) begin
      tick(p, p4);
      if (p === 1'b1) pulses++;
    end
    checks++;
    if (bus.logo_x !== 10'd260 || pulses != 0) begin
      failures++;
      $display("FAIL glitch_pos: got x=%0d pulses=%0d, want x=260 pulses=0", bus.logo_x, pulses);
    end
  endtask

  task automatic test_clamp();
    logic p, p4;
    int pulses;
    do_reset();
    set_btn4(4'b0010);
    settle();
    tick(p, p4);
    checks++;
    if (bus4.logo_x !== 10'd0 || p4 !== 1'b1) begin
      failures++;
      $display("FAIL clamp_low: got x=%0d upd=%b, want x=0 upd=1", bus4.logo_x, p4);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick(p, p4);
      if (p4 === 1'b1) pulses++;
    end
    checks++;
    if (bus4.logo_x !== 10'd0 || pulses != 0) begin
      failures++;
      $display("FAIL clamp_low_hold: got x=%0d pulses=%0d, want x=0 pulses=0", bus4.logo_x, pulses);
    end
    set_btn4(4'b0001);
    settle();
    for (int i = 0; i < 130; i++) tick(p, p4);
    checks++;
    if (bus4.logo_x !== 10'd520) begin
      failures++;
      $display("FAIL clamp_high: got x=%0d, want 520", bus4.logo_x);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick(p, p4);
      if (p4 === 1'b1) pulses++;
    end
    checks++;
    if (bus4.logo_x !== 10'd520 || pulses != 0) begin
      failures++;
      $display("FAIL clamp_high_hold: got x=%0d pulses=%0d, want x=520 pulses=0", bus4.logo_x, pulses);
    end
  endtask

  task automatic test_opposing_diagonal();
    logic p, p4;
    do_reset();
    set_btn(4'b0011);
    settle();
    tick(p, p4);
    checks++;
    if (bus.logo_x !== 10'd260 || bus.logo_y !== 10'd160 || p !== 1'b0) begin
      failures++;
      $display("FAIL opposing: got x=%0d y=%0d upd=%b, want x=260 y=160 upd=0", bus.logo_x, bus.logo_y, p);
    end
    set_btn(4'b1001);
    settle();
    tick(p, p4);
    checks++;
    if (bus.logo_x !== 10'd261 || bus.logo_y !== 10'd159 || p !== 1'b1) begin
      failures++;
      $display("FAIL diagonal: got x=%0d y=%0d upd=%b, want x=261 y=159 upd=1", bus.logo_x, bus.logo_y, p);
    end
  endtask

`ifdef LOGO_AUTO_BOUNCE_EN
  task automatic test_auto();
    logic p, p4;
    do_reset();
    for (int i = 0; i < 3; i++) tick(p, p4);
    checks++;
    if (bus.auto_mode !== 1'b0) begin
      failures++;
      $display("FAIL auto_early: got auto=%b after 3 idle ticks, want 0", bus.auto_mode);
    end
    tick(p, p4);
    checks++;
    if (bus.auto_mode !== 1'b1 || bus.logo_x !== 10'd260) begin
      failures++;
      $display("FAIL auto_enter: got auto=%b x=%0d, want auto=1 x=260", bus.auto_mode, bus.logo_x);
    end
    for (int k = 1; k <= 261; k++) begin
      tick(p, p4);
      if (k == 1 || k == 160 || k == 161 || k == 260 || k == 261) begin
        int ex, ey;
        ex = (k <= 260) ? 260 + k : 780 - k;
        ey = (k <= 160) ? 160 + k : 480 - k;
        checks++;
        if (bus.logo_x !== 10'(ex) || bus.logo_y !== 10'(ey)) begin
          failures++;
          $display("FAIL auto_move_%0d: got x=%0d y=%0d, want x=%0d y=%0d",
                   k, bus.logo_x, bus.logo_y, ex, ey);
        end
      end
    end
    set_btn(4'b1000);
    settle();
    tick(p, p4);
    checks++;
    if (bus.auto_mode !== 1'b0 || bus.logo_x !== 10'd519 || bus.logo_y !== 10'd218) begin
      failures++;
      $display("FAIL auto_exit: got auto=%b x=%0d y=%0d, want auto=0 x=519 y=218",
               bus.auto_mode, bus.logo_x, bus.logo_y);
    end
  endtask
`else
  task automatic test_auto();
    logic p, p4;
    int pulses;
    logic seen_auto;
    do_reset();
    pulses = 0;
    seen_auto = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(p, p4);
      if (p === 1'b1) pulses++;
      if (bus.auto_mode !== 1'b0) seen_auto = 1'b1;
    end
    checks++;
    if (seen_auto !== 1'b0 || pulses != 0) begin
      failures++;
      $display("FAIL no_auto: got auto_seen=%b pulses=%0d, want 0 0", seen_auto, pulses);
    end
    checks++;
    if (bus.logo_x !== 10'd260 || bus.logo_y !== 10'd160) begin
      failures++;
      $display("FAIL no_auto_pos: got x=%0d y=%0d, want x=260 y=160", bus.logo_x, bus.logo_y);
    end
  endtask
`endif

  task automatic test_reset_mid_move();
    logic p, p4;
    do_reset();
    set_btn(4'b0100);
    settle();
    tick(p, p4);
    tick(p, p4);
    checks++;
    if (bus.logo_y !== 10'd162) begin
      failures++;
      $display("FAIL down_move: got y=%0d, want 162", bus.logo_y);
    end
    rst = 1'b1;
    @(negedge pclk);
    checks++;
    if (bus.logo_x !== 10'd260 || bus.logo_y !== 10'd160 || bus.btn_state !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid: got x=%0d y=%0d btn=%b, want x=260 y=160 btn=0000",
               bus.logo_x, bus.logo_y, bus.btn_state);
    end
    rst = 1'b0;
    set_btn(4'b0000);
  endtask

  initial begin
    set_btn(4'b0000);
    set_btn4(4'b0000);
    test_reset();
    test_debounce_latency();
    test_right_hold();
    test_glitch();
    test_clamp();
    test_opposing_diagonal();
    test_auto();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
